// File: rtl/sm_accumulator.sv
// sm_accumulator
//   Registered sign-magnitude accumulator for the 3x3 convolution datapath.
//   Sums exactly N_TERMS sign-magnitude operands received over a valid/ready
//   stream and emits one saturated sign-magnitude result per group.
//
//   Parameters
//     WIDTH     : operand width, bit WIDTH-1 = sign, [WIDTH-2:0] = magnitude
//     ACC_WIDTH : result width, bit ACC_WIDTH-1 = sign, rest = magnitude
//     N_TERMS   : operands per result (>= 1)
//
//   Ports
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset
//     in_valid  : in_data valid
//     in_ready  : block accepts an operand this cycle (high while accumulating)
//     in_data   : sign-magnitude operand
//     clear     : (only with SM_ACC_CLEAR_EN) synchronous discard of the
//                 partial group; ignored while a result is pending
//     out_valid : result valid
//     out_ready : downstream accepts the result
//     out_data  : sign-magnitude sum, clamped to ACC_WIDTH
//     out_sat   : out_data was clamped
//
//   Configuration macro: SM_ACC_CLEAR_EN adds the clear input.
//
//   All outputs come straight from flops; no input reaches an output
//   combinationally.

module sm_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 12,
  parameter int N_TERMS   = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
`ifdef SM_ACC_CLEAR_EN
  input  logic                 clear,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_sat
);

  // Internal sum is wide enough that N_TERMS full-scale operands never wrap.
  localparam int SUM_W  = ACC_WIDTH + $clog2(N_TERMS) + 1;
  localparam int CNT_W  = $clog2(N_TERMS + 1);
  localparam int MAG_W  = WIDTH - 1;
  localparam int OMAG_W = ACC_WIDTH - 1;

  localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(N_TERMS - 1);
  localparam logic signed [SUM_W-1:0] MAX_MAG  =
    {{(SUM_W - OMAG_W){1'b0}}, {OMAG_W{1'b1}}};

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]              state;
  logic signed [SUM_W-1:0] acc;
  logic [CNT_W-1:0]        count;

  logic                    accept;
  logic                    clr_now;
  logic signed [SUM_W-1:0] operand;
  logic signed [SUM_W-1:0] sum_next;
  logic signed [SUM_W-1:0] sum_abs;
  logic                    sum_neg;
  logic                    sum_over;
  logic [ACC_WIDTH-1:0]    result;

  assign in_ready = (state == ST_ACCUM);
  assign accept   = in_valid && in_ready;

`ifdef SM_ACC_CLEAR_EN
  assign clr_now = clear && (state == ST_ACCUM);
`else
  assign clr_now = 1'b0;
`endif

  // Operand to two's complement, running sum, and sign-magnitude result of
  // the sum including this operand. Negative zero negates to zero, so it
  // needs no special case; a zero sum is never flagged negative.
  always_comb begin
    operand = SUM_W'(in_data[MAG_W-1:0]);
    if (in_data[WIDTH-1]) begin
      operand = -operand;
    end
    sum_next = acc + operand;
    sum_neg  = sum_next[SUM_W-1];
    sum_abs  = sum_neg ? -sum_next : sum_next;
    sum_over = (sum_abs > MAX_MAG);
    result   = {sum_neg, sum_over ? {OMAG_W{1'b1}} : sum_abs[OMAG_W-1:0]};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is a control or datapath flop and is reset;
    // there is no storage array that would be left unreset.
    if (!rst_n) begin
      state     <= ST_ACCUM;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (clr_now) begin
            // Clear wins over a simultaneous accept.
            acc   <= '0;
            count <= '0;
          end else if (accept) begin
            acc   <= sum_next;
            count <= count + CNT_W'(1);
            if (count == LAST_IDX) begin
              // Last operand of the group: register the result now so it is
              // visible the cycle after the final accept.
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              out_data  <= result;
              out_sat   <= sum_over;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_ACCUM;
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
          end
        end
        default: begin
          state <= ST_ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_accumulator.sv
// tb_sm_accumulator
//   Drives two accumulators (ACC_WIDTH 12 and 10) with identical stimulus and
//   compares every cycle against an integer reference model: accepted operands
//   are summed as plain integers and the result is clamped arithmetically.

module tb_sm_accumulator;

  localparam int N = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
`ifdef SM_ACC_CLEAR_EN
  logic       clear = 1'b0;
`endif

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [11:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [9:0]  out_data_b;

  always #5 clk = ~clk;

  sm_accumulator #(.WIDTH(8), .ACC_WIDTH(12), .N_TERMS(N)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_data   (in_data),
`ifdef SM_ACC_CLEAR_EN
    .clear     (clear),
`endif
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_data  (out_data_a),
    .out_sat   (out_sat_a)
  );

  sm_accumulator #(.WIDTH(8), .ACC_WIDTH(10), .N_TERMS(N)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_data   (in_data),
`ifdef SM_ACC_CLEAR_EN
    .clear     (clear),
`endif
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_data  (out_data_b),
    .out_sat   (out_sat_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          m_hold;
  int          m_n;
  int          m_sum;
  bit          e_valid;
  logic [11:0] e_data_a;
  bit          e_sat_a;
  logic [9:0]  e_data_b;
  bit          e_sat_b;
  string       phase;

  function automatic int sm_val(input logic [7:0] d);
    int mag;
    mag = int'(d[6:0]);
    return d[7] ? -mag : mag;
  endfunction

  function automatic logic [31:0] to_sm(input int s, input int aw,
                                        output bit sat);
    int mx;
    int a;
    mx  = (1 << (aw - 1)) - 1;
    a   = (s < 0) ? -s : s;
    sat = (a > mx);
    if (sat) a = mx;
    return ((s < 0) ? (1 << (aw - 1)) : 0) | a;
  endfunction

  task automatic model_reset();
    m_hold   = 0;
    m_n      = 0;
    m_sum    = 0;
    e_valid  = 0;
    e_data_a = '0;
    e_sat_a  = 0;
    e_data_b = '0;
    e_sat_b  = 0;
  endtask

  task automatic check_outputs();
    check({phase, "/in_ready_a"},  32'(in_ready_a),  32'(!m_hold));
    check({phase, "/in_ready_b"},  32'(in_ready_b),  32'(!m_hold));
    check({phase, "/out_valid_a"}, 32'(out_valid_a), 32'(e_valid));
    check({phase, "/out_valid_b"}, 32'(out_valid_b), 32'(e_valid));
    check({phase, "/out_data_a"},  32'(out_data_a),  32'(e_data_a));
    check({phase, "/out_data_b"},  32'(out_data_b),  32'(e_data_b));
    check({phase, "/out_sat_a"},   32'(out_sat_a),   32'(e_sat_a));
    check({phase, "/out_sat_b"},   32'(out_sat_b),   32'(e_sat_b));
  endtask

  // Called at a falling edge: drive inputs, predict the effect of the next
  // rising edge, then compare at the following falling edge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit r,
                       input bit clr);
    bit sa, sb;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
`ifdef SM_ACC_CLEAR_EN
    clear = clr;
`endif
    if (!m_hold) begin
      if (clr) begin
        m_sum = 0;
        m_n   = 0;
      end else if (v) begin
        m_sum += sm_val(d);
        m_n++;
        if (m_n == N) begin
          m_hold   = 1;
          e_valid  = 1;
          e_data_a = 12'(to_sm(m_sum, 12, sa));
          e_sat_a  = sa;
          e_data_b = 10'(to_sm(m_sum, 10, sb));
          e_sat_b  = sb;
        end
      end
    end else if (r) begin
      m_hold  = 0;
      e_valid = 0;
      m_sum   = 0;
      m_n     = 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef SM_ACC_CLEAR_EN
    clear = 1'b0;
`endif
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    phase = "reset";
    do_reset();

    // 9 x +5 back to back
    phase = "t1";
    for (int i = 0; i < N; i++) cycle(1, 8'h05, 1, 0);
    check("t1/valid", 32'(out_valid_a), 32'd1);
    check("t1/data", 32'(out_data_a), 32'h02D);
    check("t1/sat", 32'(out_sat_a), 32'd0);
    cycle(0, 8'h00, 1, 0);

    // 4 x +127, 5 x -127 -> -127
    phase = "t2";
    for (int i = 0; i < N; i++) cycle(1, (i < 4) ? 8'h7F : 8'hFF, 1, 0);
    check("t2/data", 32'(out_data_a), 32'h87F);
    check("t2/sat", 32'(out_sat_a), 32'd0);
    cycle(0, 8'h00, 1, 0);

    // +3/-3 pairs plus negative zero -> plain zero
    phase = "t2z";
    for (int i = 0; i < 8; i++) cycle(1, i[0] ? 8'h83 : 8'h03, 1, 0);
    cycle(1, 8'h80, 1, 0);
    check("t2z/data_a", 32'(out_data_a), 32'h000);
    check("t2z/data_b", 32'(out_data_b), 32'h000);
    cycle(0, 8'h00, 1, 0);

    // saturation on the 10-bit instance
    phase = "t3p";
    for (int i = 0; i < N; i++) cycle(1, 8'h7F, 1, 0);
    check("t3p/data_b", 32'(out_data_b), 32'h1FF);
    check("t3p/sat_b", 32'(out_sat_b), 32'd1);
    check("t3p/data_a", 32'(out_data_a), 32'h477);
    cycle(0, 8'h00, 1, 0);
    phase = "t3n";
    for (int i = 0; i < N; i++) cycle(1, 8'hFF, 1, 0);
    check("t3n/data_b", 32'(out_data_b), 32'h3FF);
    check("t3n/sat_b", 32'(out_sat_b), 32'd1);
    cycle(0, 8'h00, 1, 0);

    // backpressure: result held, operands refused
    phase = "t4";
    for (int i = 0; i < N; i++) cycle(1, 8'h11, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 8'h22, 0, 0);
      check("t4/in_ready", 32'(in_ready_a), 32'd0);
      check("t4/data", 32'(out_data_a), 32'h099);
    end
    cycle(1, 8'h22, 1, 0);
    for (int i = 0; i < N; i++) cycle(1, 8'h01, 1, 0);
    check("t4/next", 32'(out_data_a), 32'h009);
    cycle(0, 8'h00, 1, 0);

    // reset mid-group discards partial sum
    phase = "t5";
    for (int i = 0; i < 4; i++) cycle(1, 8'h33, 1, 0);
    do_reset();
    phase = "t5b";
    for (int i = 0; i < N; i++) cycle(1, 8'h01, 1, 0);
    check("t5/data", 32'(out_data_a), 32'h009);
    cycle(0, 8'h00, 1, 0);

`ifdef SM_ACC_CLEAR_EN
    phase = "t6";
    for (int i = 0; i < 3; i++) cycle(1, 8'h10, 1, 0);
    cycle(1, 8'h10, 1, 1);
    for (int i = 0; i < N; i++) cycle(1, 8'h02, 0, 0);
    check("t6/data", 32'(out_data_a), 32'h012);
    cycle(1, 8'h05, 0, 1);
    cycle(0, 8'h05, 0, 1);
    check("t6/hold_data", 32'(out_data_a), 32'h012);
    check("t6/hold_valid", 32'(out_valid_a), 32'd1);
    cycle(0, 8'h00, 1, 0);
`endif

    // randomized traffic
    phase = "rand";
    for (int i = 0; i < 1500; i++) begin
      bit clr_r;
      clr_r = 0;
`ifdef SM_ACC_CLEAR_EN
      clr_r = ($urandom_range(0, 15) == 0);
`endif
      cycle($urandom_range(0, 3) != 0, 8'($urandom),
            $urandom_range(0, 2) != 0, clr_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
